// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared types and constants for the sequenced IJTAG/functional data mux.
package firebird7_in_gate1_tessent_data_mux_pkg;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned HOLD_MAX = 15;

    typedef enum logic [1:0] {
        FUNC     = 2'd0,
        HOLD_IN  = 2'd1,
        IJTAG    = 2'd2,
        HOLD_OUT = 2'd3
    } mux_state_e;

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_chan.sv
// One mux channel: update registers, switchover FSM with frozen hold value, output select.
module firebird7_in_gate1_tessent_data_mux_chan
    import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ue_i,
    input  logic             sel_i,
    input  logic [WIDTH-1:0] upd_i,
    input  logic [WIDTH-1:0] func_i,
    output logic [WIDTH-1:0] data_o,
    output logic             active_o,
    output logic             hold_o
);

    localparam logic [CNT_W-1:0] CntInit = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    mux_state_e       state_q, state_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] upd_q, upd_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sel_d   = ue_i ? sel_i : sel_q;
        upd_d   = ue_i ? upd_i : upd_q;
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        case (state_q)
            FUNC: begin
                if (sel_q) begin
                    state_d = HOLD_IN;
                    hold_d  = func_i;
                    cnt_d   = CntInit;
                end
            end
            HOLD_IN: begin
                if (cnt_q == '0) state_d = IJTAG;
                else             cnt_d   = cnt_q - CntOne;
            end
            IJTAG: begin
                if (!sel_q) begin
                    state_d = HOLD_OUT;
                    hold_d  = upd_q;
                    cnt_d   = CntInit;
                end
            end
            HOLD_OUT: begin
                if (cnt_q == '0) state_d = FUNC;
                else             cnt_d   = cnt_q - CntOne;
            end
            default: state_d = FUNC;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FUNC;
            sel_q   <= 1'b0;
            upd_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            upd_q   <= upd_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    // Functional path stays purely combinational while in FUNC.
    always_comb begin
        case (state_q)
            FUNC:    data_o = func_i;
            IJTAG:   data_o = upd_q;
            default: data_o = hold_q;
        endcase
    end

    assign active_o = (state_q == IJTAG);
    assign hold_o   = (state_q == HOLD_IN) || (state_q == HOLD_OUT);

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_seq.sv
// Multi-channel sequenced IJTAG data mux top. Optional readback capture register is enabled
// with the FIREBIRD7_DATA_MUX_READBACK_EN macro.
module firebird7_in_gate1_tessent_data_mux_seq
    import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                      ijtag_tck,
    input  logic                      ijtag_reset,
    input  logic                      ijtag_ue,
    input  logic [CHANNELS-1:0]       ijtag_select,
    input  logic [CHANNELS*WIDTH-1:0] ijtag_data_in,
    input  logic [CHANNELS*WIDTH-1:0] functional_data_in,
`ifdef FIREBIRD7_DATA_MUX_READBACK_EN
    input  logic                      ijtag_ce,
    output logic [CHANNELS*WIDTH-1:0] captured_data,
`endif
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]       ijtag_active,
    output logic                      busy
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > HOLD_MAX) begin : g_bad_hold
        $error("HOLD_CYCLES out of range 1..15");
    end

    logic [CHANNELS-1:0] hold_flags;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        firebird7_in_gate1_tessent_data_mux_chan #(
            .WIDTH       (WIDTH),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_chan (
            .clk_i    (ijtag_tck),
            .rst_ni   (ijtag_reset),
            .ue_i     (ijtag_ue),
            .sel_i    (ijtag_select[c]),
            .upd_i    (ijtag_data_in[c*WIDTH +: WIDTH]),
            .func_i   (functional_data_in[c*WIDTH +: WIDTH]),
            .data_o   (data_out[c*WIDTH +: WIDTH]),
            .active_o (ijtag_active[c]),
            .hold_o   (hold_flags[c])
        );
    end

    assign busy = |hold_flags;

`ifdef FIREBIRD7_DATA_MUX_READBACK_EN
    logic [CHANNELS*WIDTH-1:0] captured_q, captured_d;

    always_comb begin
        captured_d = ijtag_ce ? data_out : captured_q;
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) captured_q <= '0;
        else              captured_q <= captured_d;
    end

    assign captured_data = captured_q;
`endif

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_seq.sv
// Directed bench for the sequenced data mux (WIDTH=3, CHANNELS=4, HOLD_CYCLES=2).
module tb_firebird7_in_gate1_tessent_data_mux_seq;

    logic        ijtag_tck = 1'b0;
    logic        ijtag_reset;
    logic        ijtag_ue;
    logic [3:0]  ijtag_select;
    logic [11:0] ijtag_data_in;
    logic [11:0] functional_data_in;
    logic [11:0] data_out;
    logic [3:0]  ijtag_active;
    logic        busy;
`ifdef FIREBIRD7_DATA_MUX_READBACK_EN
    logic        ijtag_ce;
    logic [11:0] captured_data;
`endif

    int checks = 0;
    int errors = 0;

    firebird7_in_gate1_tessent_data_mux_seq #(
        .WIDTH       (3),
        .CHANNELS    (4),
        .HOLD_CYCLES (2)
    ) dut (
        .ijtag_tck          (ijtag_tck),
        .ijtag_reset        (ijtag_reset),
        .ijtag_ue           (ijtag_ue),
        .ijtag_select       (ijtag_select),
        .ijtag_data_in      (ijtag_data_in),
        .functional_data_in (functional_data_in),
`ifdef FIREBIRD7_DATA_MUX_READBACK_EN
        .ijtag_ce           (ijtag_ce),
        .captured_data      (captured_data),
`endif
        .data_out           (data_out),
        .ijtag_active       (ijtag_active),
        .busy               (busy)
    );

    always #5 ijtag_tck = ~ijtag_tck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ijtag_tck);
        @(negedge ijtag_tck);
    endtask

    // Octal literals: one digit per channel, ch3 leftmost.
    initial begin
        ijtag_reset        = 1'b0;
        ijtag_ue           = 1'b0;
        ijtag_select       = 4'b0000;
        ijtag_data_in      = 12'o0000;
        functional_data_in = 12'hABC;
`ifdef FIREBIRD7_DATA_MUX_READBACK_EN
        ijtag_ce           = 1'b0;
`endif
        #1;
        chk("rst_data", 32'(data_out), 32'hABC);
        chk("rst_active", 32'(ijtag_active), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
`ifdef FIREBIRD7_DATA_MUX_READBACK_EN
        chk("rst_capt", 32'(captured_data), 32'h0);
`endif
        functional_data_in = 12'h123;
        #1;
        chk("rst_func_comb", 32'(data_out), 32'h123);

        @(negedge ijtag_tck);
        ijtag_reset = 1'b1;
        step();

        // Select ch0: upd 101, func 010.
        functional_data_in = 12'o5432;
        ijtag_data_in      = 12'o0005;
        ijtag_select       = 4'b0001;
        ijtag_ue           = 1'b1;
        step();
        ijtag_ue = 1'b0;
        chk("sel_upd_func", 32'(data_out), 32'o5432);
        chk("sel_upd_busy", 32'(busy), 32'h0);
        step();
        chk("hin1_busy", 32'(busy), 32'h1);
        functional_data_in = 12'o5437;
        #1;
        chk("hin1_data", 32'(data_out), 32'o5432);
        step();
        chk("hin2_busy", 32'(busy), 32'h1);
        chk("hin2_data", 32'(data_out), 32'o5432);
        chk("hin2_active", 32'(ijtag_active), 32'h0);
        step();
        chk("ij_active", 32'(ijtag_active), 32'h1);
        chk("ij_busy", 32'(busy), 32'h0);
        chk("ij_data", 32'(data_out), 32'o5435);

        // New update value while in IJTAG.
        ijtag_data_in = 12'o0003;
        ijtag_ue      = 1'b1;
        step();
        ijtag_ue = 1'b0;
        chk("ij_upd_data", 32'(data_out), 32'o5433);

        // Release from IJTAG.
        ijtag_select = 4'b0000;
        ijtag_ue     = 1'b1;
        step();
        ijtag_ue = 1'b0;
        chk("rel_k_active", 32'(ijtag_active), 32'h1);
        step();
        chk("hout1_busy", 32'(busy), 32'h1);
        chk("hout1_active", 32'(ijtag_active), 32'h0);
        functional_data_in = 12'o5430;
        #1;
        chk("hout1_data", 32'(data_out), 32'o5433);
        step();
        chk("hout2_data", 32'(data_out), 32'o5433);
        step();
        chk("func_back_data", 32'(data_out), 32'o5430);
        chk("func_back_busy", 32'(busy), 32'h0);

        // Deselect while in HOLD_IN: hold completes, then releases.
        ijtag_data_in = 12'o0005;
        ijtag_select  = 4'b0001;
        ijtag_ue      = 1'b1;
        step();
        ijtag_select = 4'b0000;
        step();
        ijtag_ue = 1'b0;
        chk("abort_hin_busy", 32'(busy), 32'h1);
        step();
        chk("abort_hin2_busy", 32'(busy), 32'h1);
        step();
        chk("abort_ij_active", 32'(ijtag_active), 32'h1);
        chk("abort_ij_data", 32'(data_out), 32'o5435);
        step();
        chk("abort_hout1_busy", 32'(busy), 32'h1);
        chk("abort_hout1_data", 32'(data_out), 32'o5435);
        step();
        chk("abort_hout2_data", 32'(data_out), 32'o5435);
        step();
        chk("abort_func_data", 32'(data_out), 32'o5430);
        chk("abort_func_busy", 32'(busy), 32'h0);

        // ch1 and ch3 together.
        ijtag_data_in = 12'o6070;
        ijtag_select  = 4'b1010;
        ijtag_ue      = 1'b1;
        step();
        ijtag_ue = 1'b0;
        step();
        functional_data_in = 12'o1111;
        #1;
        chk("pair_hin_data", 32'(data_out), 32'o5131);
        chk("pair_hin_busy", 32'(busy), 32'h1);
        step();
        step();
        chk("pair_ij_active", 32'(ijtag_active), 32'b1010);
        chk("pair_ij_data", 32'(data_out), 32'o6171);
        chk("pair_ij_busy", 32'(busy), 32'h0);
`ifdef FIREBIRD7_DATA_MUX_READBACK_EN
        ijtag_ce = 1'b1;
        step();
        ijtag_ce = 1'b0;
        chk("capt_ij", 32'(captured_data), 32'o6171);
        functional_data_in = 12'o1112;
        step();
        chk("capt_hold", 32'(captured_data), 32'o6171);
        functional_data_in = 12'o1111;
`endif

        // Add ch0, then reset asynchronously in the middle of its HOLD_IN.
        ijtag_data_in = 12'o6074;
        ijtag_select  = 4'b1011;
        ijtag_ue      = 1'b1;
        step();
        ijtag_ue = 1'b0;
        step();
        functional_data_in = 12'o2222;
        #1;
        chk("mix_data", 32'(data_out), 32'o6271);
        chk("mix_busy", 32'(busy), 32'h1);
        #1;
        ijtag_reset = 1'b0;
        #1;
        chk("async_rst_data", 32'(data_out), 32'o2222);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_active", 32'(ijtag_active), 32'h0);
`ifdef FIREBIRD7_DATA_MUX_READBACK_EN
        chk("async_rst_capt", 32'(captured_data), 32'h0);
`endif
        @(negedge ijtag_tck);
        ijtag_reset = 1'b1;
        step();
        step();
        chk("post_rst_data", 32'(data_out), 32'o2222);
        chk("post_rst_active", 32'(ijtag_active), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
